// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock divider: default counter width,
// ratio in force after reset, and the period-counter width.
package clkdiv_pkg;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_DIV      = 6;
    localparam int PERIOD_CNT_W = 16;

endpackage

// File: rtl/clk_divider_prog_if.sv
// Control/status bundle of clk_divider_prog. O_PERIODS exists only when
// CLKDIV_PERIOD_CNT_EN is defined.
interface clk_divider_prog_if
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             div_pend;
    logic             div_err;
    logic [CNT_W-1:0] cur_div;
    logic             O_CLK;
    logic             O_TICK;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] O_PERIODS;
`endif

`ifdef CLKDIV_PERIOD_CNT_EN
    modport master (output en, div_in, div_load,
                    input  div_pend, div_err, cur_div, O_CLK, O_TICK, O_PERIODS);
    modport slave  (input  en, div_in, div_load,
                    output div_pend, div_err, cur_div, O_CLK, O_TICK, O_PERIODS);
`else
    modport master (output en, div_in, div_load,
                    input  div_pend, div_err, cur_div, O_CLK, O_TICK);
    modport slave  (input  en, div_in, div_load,
                    output div_pend, div_err, cur_div, O_CLK, O_TICK);
`endif

endinterface

// File: rtl/clkdiv_ratio_reg.sv
// Ratio bookkeeping: holds the ratio in force, a pending ratio waiting for the
// next period boundary, and the zero-ratio error pulse.
module clkdiv_ratio_reg
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             period_end_i,
    input  logic             div_load_i,
    input  logic [CNT_W-1:0] div_in_i,
    output logic [CNT_W-1:0] cur_div_o,
    output logic [CNT_W-1:0] pend_div_o,
    output logic             div_pend_o,
    output logic             div_err_o,
    output logic             apply_o
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             div_pend_q, div_pend_d;
    logic             div_err_q, div_err_d;
    logic             load_ok;

    assign load_ok = div_load_i && (div_in_i != '0);
    assign apply_o = period_end_i && div_pend_q;

    // The old pending value is applied before a same-cycle load replaces it.
    always_comb begin
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        div_pend_d = div_pend_q;
        div_err_d  = div_load_i && (div_in_i == '0);
        if (apply_o) begin
            cur_div_d  = pend_div_q;
            div_pend_d = 1'b0;
        end
        if (load_ok) begin
            pend_div_d = div_in_i;
            div_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_div_q  <= DIV_RST;
            pend_div_q <= '0;
            div_pend_q <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            div_pend_q <= div_pend_d;
            div_err_q  <= div_err_d;
        end
    end

    assign cur_div_o  = cur_div_q;
    assign pend_div_o = pend_div_q;
    assign div_pend_o = div_pend_q;
    assign div_err_o  = div_err_q;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider with enable, one-cycle tick and glitch-free
// ratio reload. Optional O_PERIODS counter under CLKDIV_PERIOD_CNT_EN.
module clk_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic               I_CLK,
    input  logic               rst,
    clk_divider_prog_if.slave  bus
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div, pend_div, n_eff;
    logic             div_pend, div_err, apply;
    logic             wrap;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    assign wrap = (cnt_q == (cur_div - ONE));

    clkdiv_ratio_reg #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ratio (
        .clk_i        (I_CLK),
        .rst_i        (rst),
        .period_end_i (bus.en && wrap),
        .div_load_i   (bus.div_load),
        .div_in_i     (bus.div_in),
        .cur_div_o    (cur_div),
        .pend_div_o   (pend_div),
        .div_pend_o   (div_pend),
        .div_err_o    (div_err),
        .apply_o      (apply)
    );

    // On the apply edge the outputs already follow the newly applied ratio.
    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        n_eff  = apply ? pend_div : cur_div;
        if (bus.en) begin
            cnt_d  = wrap ? '0 : cnt_q + ONE;
            tick_d = (cnt_d == '0);
            clk_d  = (n_eff == ONE) || (cnt_d < (n_eff >> 1));
        end
    end

    always_ff @(posedge I_CLK) begin
        if (rst) begin
            cnt_q  <= DIV_RST - ONE;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] periods_q, periods_d;

    assign periods_d = tick_d ? periods_q + PERIOD_CNT_W'(1) : periods_q;

    always_ff @(posedge I_CLK) begin
        if (rst) periods_q <= '0;
        else     periods_q <= periods_d;
    end

    assign bus.O_PERIODS = periods_q;
`else
    // Period counter not built in this configuration.
`endif

    assign bus.O_CLK    = clk_q;
    assign bus.O_TICK   = tick_q;
    assign bus.cur_div  = cur_div;
    assign bus.div_pend = div_pend;
    assign bus.div_err  = div_err;

endmodule
